// File: rtl/elevator_pkg.sv
// Shared command and sensor encodings for the elevator controller and plant model.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package elevator_pkg;

  typedef logic [1:0] code_t;

  typedef enum logic [1:0] {
    ENG_STOP    = 2'b00,
    ENG_UP      = 2'b01,
    ENG_DOWN    = 2'b10,
    ENG_ILLEGAL = 2'b11
  } engine_e;

  typedef enum logic [1:0] {
    DOOR_HOLD    = 2'b00,
    DOOR_OPEN    = 2'b01,
    DOOR_CLOSE   = 2'b10,
    DOOR_ILLEGAL = 2'b11
  } door_e;

  typedef enum logic [1:0] {
    SDOOR_CLOSED  = 2'b00,
    SDOOR_PARTIAL = 2'b01,
    SDOOR_OPEN    = 2'b10
  } sdoor_e;

  // Door sensor encoding; 2'b11 can never be produced.
  function automatic code_t sdoor_encode(input logic closed, input logic full);
    if (closed)    return SDOOR_CLOSED;
    else if (full) return SDOOR_OPEN;
    else           return SDOOR_PARTIAL;
  endfunction

endpackage

// File: rtl/elevator_shaft_model_if.sv
// Command/sensor bundle between elevator controller (master) and plant model (slave).
// Latency: n/a (wires only).
// Backpressure: none; commands are levels sampled every clock.
// Signals: engine, door, obstruct (master->slave); sensor_door, sensor_up,
// sensor_down, floor_pos, at_floor, fault (slave->master).
interface elevator_shaft_model_if
  import elevator_pkg::*;
#(
  parameter int FLOOR_W = 3
);
  code_t              engine;
  code_t              door;
  logic               obstruct;
  code_t              sensor_door;
  logic               sensor_up;
  logic               sensor_down;
  logic [FLOOR_W-1:0] floor_pos;
  logic               at_floor;
  logic               fault;

  modport master (
    output engine, door, obstruct,
    input  sensor_door, sensor_up, sensor_down, floor_pos, at_floor, fault
  );

  modport slave (
    input  engine, door, obstruct,
    output sensor_door, sensor_up, sensor_down, floor_pos, at_floor, fault
  );
endinterface

// File: rtl/door_actuator_model.sv
// Door actuator: dpos counter 0..DELAY_DOOR with obstruction reversal and sensor encoding.
// Latency: enable sampled at an edge moves dpos at that edge; sensors follow state.
// Backpressure: none; open/close enables are pre-qualified by the parent.
// Ports: clock, reset (sync, active-low), open_en, close_en, obstruct in;
// sensor_door, door_closed out.
module door_actuator_model
  import elevator_pkg::*;
#(
  parameter int DELAY_DOOR = 10
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  open_en,
  input  logic  close_en,
  input  logic  obstruct,
  output code_t sensor_door,
  output logic  door_closed
);

  localparam int             DP_W    = $clog2(DELAY_DOOR + 1);
  localparam logic [DP_W-1:0] DP_FULL = DP_W'(DELAY_DOOR);

  logic [DP_W-1:0] dpos_q;
  logic [DP_W-1:0] dpos_d;
  logic            full;

  assign full        = (dpos_q == DP_FULL);
  assign door_closed = (dpos_q == '0);

  always_comb begin
    dpos_d = dpos_q;
    if (open_en && !full) begin
      dpos_d = dpos_q + 1'b1;
    end else if (close_en && !door_closed) begin
      // A broken beam while closing drives the door back open, stopping at full.
      if (obstruct) begin
        if (!full) dpos_d = dpos_q + 1'b1;
      end else begin
        dpos_d = dpos_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) dpos_q <= '0;
    else        dpos_q <= dpos_d;
  end

  assign sensor_door = sdoor_encode(door_closed, full);

endmodule

// File: rtl/elevator_shaft_model.sv
// Elevator plant model: car position in a shaft of FLOORS floors plus door, with sticky fault.
// Latency: commands sampled at an edge are reflected in the outputs right after that edge.
// Backpressure: none; illegal or unsafe commands are suppressed and latch fault until reset.
// Ports: clock, reset (sync, active-low); bus (slave modport) carries engine/door/obstruct
// in and sensor_door/sensor_up/sensor_down/floor_pos/at_floor/fault out.
module elevator_shaft_model
  import elevator_pkg::*;
#(
  parameter int FLOORS       = 8,
  parameter int FLOOR_W      = 3,
  parameter int DELAY_ENGINE = 10,
  parameter int DELAY_DOOR   = 10,
  parameter int START_FLOOR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  elevator_shaft_model_if.slave bus
);

  localparam int                 OFF_W       = $clog2(DELAY_ENGINE);
  localparam logic [OFF_W-1:0]   OFF_LAST    = OFF_W'(DELAY_ENGINE - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_TOP   = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_START = FLOOR_W'(START_FLOOR);

  // Position is kept as (floor, offset within floor) rather than one linear count.
  logic [FLOOR_W-1:0] floor_q;
  logic [OFF_W-1:0]   offset_q;
  logic               fault_q;

  logic aligned;
  logic top_aligned;
  logic bottom_aligned;
  logic door_closed;

  logic eng_up;
  logic eng_down;
  logic eng_any;
  logic door_open_cmd;
  logic door_close_cmd;
  logic conflict;
  logic move_up;
  logic move_down;
  logic open_en;
  logic close_en;
  logic fault_set;

  assign aligned        = (offset_q == '0);
  assign top_aligned    = aligned && (floor_q == FLOOR_TOP);
  assign bottom_aligned = aligned && (floor_q == '0);

  assign eng_up         = (bus.engine == ENG_UP);
  assign eng_down       = (bus.engine == ENG_DOWN);
  assign eng_any        = (bus.engine != ENG_STOP);
  assign door_open_cmd  = (bus.door == DOOR_OPEN);
  assign door_close_cmd = (bus.door == DOOR_CLOSE);

  // Engine and door commanded together: neither actuator is allowed to move.
  assign conflict = eng_any && (door_open_cmd || door_close_cmd);

  // The top floor can only be reached aligned, so "not top_aligned" also bounds pos.
  assign move_up   = eng_up   && door_closed && !top_aligned    && !conflict;
  assign move_down = eng_down && door_closed && !bottom_aligned && !conflict;

  // Door moves only with the engine fully stopped; an illegal engine code also blocks it.
  assign open_en  = door_open_cmd  && !eng_any && aligned;
  assign close_en = door_close_cmd && !eng_any;

  assign fault_set = (bus.engine == ENG_ILLEGAL)
                  || (bus.door == DOOR_ILLEGAL)
                  || (eng_up && top_aligned)
                  || (eng_down && bottom_aligned)
                  || (eng_any && !door_closed)
                  || (door_open_cmd && !aligned)
                  || conflict;

  always_ff @(posedge clock) begin
    if (!reset) begin
      floor_q  <= FLOOR_START;
      offset_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (fault_set) fault_q <= 1'b1;
      if (move_up) begin
        if (offset_q == OFF_LAST) begin
          offset_q <= '0;
          floor_q  <= floor_q + 1'b1;
        end else begin
          offset_q <= offset_q + 1'b1;
        end
      end else if (move_down) begin
        if (offset_q == '0) begin
          offset_q <= OFF_LAST;
          floor_q  <= floor_q - 1'b1;
        end else begin
          offset_q <= offset_q - 1'b1;
        end
      end
    end
  end

  door_actuator_model #(
    .DELAY_DOOR (DELAY_DOOR)
  ) u_door (
    .clock       (clock),
    .reset       (reset),
    .open_en     (open_en),
    .close_en    (close_en),
    .obstruct    (bus.obstruct),
    .sensor_door (bus.sensor_door),
    .door_closed (door_closed)
  );

  assign bus.floor_pos   = floor_q;
  assign bus.at_floor    = aligned;
  assign bus.sensor_up   = top_aligned;
  assign bus.sensor_down = bottom_aligned;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Self-checking bench for elevator_shaft_model: directed scenarios then random command runs.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_elevator_shaft_model;

  localparam int FLOORS = 8;
  localparam int FLOOR_W = 3;
  localparam int DE = 10;
  localparam int DD = 10;
  localparam int START = 0;
  localparam int POS_MAX = (FLOORS - 1) * DE;

  logic clock = 1'b0;
  logic reset = 1'b0;

  elevator_shaft_model_if #(.FLOOR_W(FLOOR_W)) bus ();

  elevator_shaft_model #(
    .FLOORS       (FLOORS),
    .FLOOR_W      (FLOOR_W),
    .DELAY_ENGINE (DE),
    .DELAY_DOOR   (DD),
    .START_FLOOR  (START)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: linear car position and door position as plain integers.
  int m_pos;
  int m_dpos;
  bit m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst_n, input int eng, input int dr, input bit ob);
    bit at;
    bit door_cmd;
    if (!rst_n) begin
      m_pos = START * DE;
      m_dpos = 0;
      m_fault = 0;
      return;
    end
    at = (m_pos % DE) == 0;
    door_cmd = (dr == 1) || (dr == 2);
    if (eng == 3 || dr == 3) m_fault = 1;
    if (eng == 1 && m_pos == POS_MAX) m_fault = 1;
    if (eng == 2 && m_pos == 0) m_fault = 1;
    if (eng != 0 && m_dpos != 0) m_fault = 1;
    if (dr == 1 && !at) m_fault = 1;
    if (eng != 0 && door_cmd) m_fault = 1;
    if (eng == 1 && m_dpos == 0 && m_pos < POS_MAX && !door_cmd) m_pos++;
    else if (eng == 2 && m_dpos == 0 && m_pos > 0 && !door_cmd) m_pos--;
    if (eng == 0) begin
      if (dr == 1 && at && m_dpos < DD) m_dpos++;
      else if (dr == 2 && m_dpos > 0) begin
        if (ob) m_dpos = (m_dpos < DD) ? m_dpos + 1 : DD;
        else    m_dpos--;
      end
    end
  endtask

  task automatic check_model();
    int fl;
    bit at;
    int sd;
    fl = m_pos / DE;
    at = (m_pos % DE) == 0;
    sd = (m_dpos == 0) ? 0 : ((m_dpos == DD) ? 2 : 1);
    chk("floor_pos", 32'(bus.floor_pos), fl);
    chk("at_floor", 32'(bus.at_floor), 32'(at));
    chk("sensor_up", 32'(bus.sensor_up), 32'(at && fl == FLOORS - 1));
    chk("sensor_down", 32'(bus.sensor_down), 32'(at && fl == 0));
    chk("sensor_door", 32'(bus.sensor_door), sd);
    chk("fault", 32'(bus.fault), 32'(m_fault));
  endtask

  // One clock: drive, clock edge, advance model, then compare 1 unit after the edge.
  task automatic cyc(input bit rst_n, input int eng, input int dr, input bit ob);
    reset = rst_n;
    bus.engine = 2'(eng);
    bus.door = 2'(dr);
    bus.obstruct = ob;
    @(posedge clock);
    model_step(rst_n, eng, dr, ob);
    #1;
    check_model();
  endtask

  task automatic run(input int n, input int eng, input int dr, input bit ob);
    for (int i = 0; i < n; i++) cyc(1'b1, eng, dr, ob);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int eng, dr, len;
    bit ob;
    bus.engine = 2'b00;
    bus.door = 2'b00;
    bus.obstruct = 1'b0;
    m_pos = 0;
    m_dpos = 0;
    m_fault = 0;

    // 1: reset then one floor up.
    cyc(1'b0, 0, 0, 0);
    chk("rst_sensor_door", 32'(bus.sensor_door), 0);
    chk("rst_at_floor", 32'(bus.at_floor), 1);
    chk("rst_sensor_down", 32'(bus.sensor_down), 1);
    chk("rst_sensor_up", 32'(bus.sensor_up), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 1, 0, 0);
      chk("t1_between_at_floor", 32'(bus.at_floor), 0);
      chk("t1_sensor_down", 32'(bus.sensor_down), 0);
    end
    cyc(1'b1, 1, 0, 0);
    chk("t1_floor_pos", 32'(bus.floor_pos), 1);
    chk("t1_at_floor", 32'(bus.at_floor), 1);

    // 2: travel to top, then push past it.
    cyc(1'b0, 0, 0, 0);
    run(70, 1, 0, 0);
    chk("t2_floor_pos", 32'(bus.floor_pos), 7);
    chk("t2_sensor_up", 32'(bus.sensor_up), 1);
    chk("t2_fault_before", 32'(bus.fault), 0);
    run(5, 1, 0, 0);
    chk("t2_floor_pos_hold", 32'(bus.floor_pos), 7);
    chk("t2_at_floor_hold", 32'(bus.at_floor), 1);
    chk("t2_fault", 32'(bus.fault), 1);

    // 3: open door fully, then engine with door open.
    cyc(1'b0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 0, 1, 0);
      chk("t3_door_partial", 32'(bus.sensor_door), 1);
    end
    cyc(1'b1, 0, 1, 0);
    chk("t3_door_open", 32'(bus.sensor_door), 2);
    run(3, 1, 0, 0);
    chk("t3_floor_pos", 32'(bus.floor_pos), 0);
    chk("t3_at_floor", 32'(bus.at_floor), 1);
    chk("t3_fault", 32'(bus.fault), 1);

    // 4: obstruction reopens during close.
    cyc(1'b0, 0, 0, 0);
    run(10, 0, 1, 0);
    run(4, 0, 2, 0);
    run(2, 0, 2, 1);
    run(7, 0, 2, 0);
    chk("t4_door_still_partial", 32'(bus.sensor_door), 1);
    run(1, 0, 2, 0);
    chk("t4_door_closed", 32'(bus.sensor_door), 0);
    chk("t4_fault", 32'(bus.fault), 0);

    // 5: door open request between floors.
    run(5, 1, 0, 0);
    run(3, 0, 1, 0);
    chk("t5_sensor_door", 32'(bus.sensor_door), 0);
    chk("t5_at_floor", 32'(bus.at_floor), 0);
    chk("t5_fault", 32'(bus.fault), 1);

    // 6: reset mid-travel with fault set.
    cyc(1'b0, 0, 0, 0);
    run(1, 3, 0, 0);
    run(25, 1, 0, 0);
    chk("t6_pre_floor_pos", 32'(bus.floor_pos), 2);
    chk("t6_pre_fault", 32'(bus.fault), 1);
    cyc(1'b0, 1, 0, 0);
    chk("t6_floor_pos", 32'(bus.floor_pos), 0);
    chk("t6_at_floor", 32'(bus.at_floor), 1);
    chk("t6_sensor_down", 32'(bus.sensor_down), 1);
    chk("t6_sensor_door", 32'(bus.sensor_door), 0);
    chk("t6_fault", 32'(bus.fault), 0);

    // Random runs of held commands, with occasional resets.
    for (int r = 0; r < 300; r++) begin
      int pick;
      pick = int'($urandom_range(0, 99));
      eng = (pick < 45) ? 0 : (pick < 70) ? 1 : (pick < 95) ? 2 : 3;
      pick = int'($urandom_range(0, 99));
      dr = (pick < 35) ? 0 : (pick < 65) ? 1 : (pick < 97) ? 2 : 3;
      ob = ($urandom_range(0, 3) == 0);
      len = int'($urandom_range(1, 15));
      if ($urandom_range(0, 39) == 0) cyc(1'b0, eng, dr, ob);
      for (int k = 0; k < len; k++) cyc(1'b1, eng, dr, ob);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
